pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline register bank: generates per-stage EN/FLUSH, PC enable and PC select.
//  Handles memory waits, load-use stalls, jumps and branch/JR squash, and the halt drain sequence.
//  Sits beside the pipeline registers in the datapath top; keeps stall/flush performance counters.
// PARAMETERS
//  CNT_W  32  width of stall_cnt / flush_cnt (saturating)
// PORTS
//  CLK          in   1      clock, rising edge
//  nRST         in   1      asynchronous active-low reset
//  ihit         in   1      instruction fetch complete this cycle
//  dhit         in   1      data access complete this cycle
//  dec_rs       in   5      rs of instr in decode (IF/ID reg)
//  dec_rt       in   5      rt of instr in decode
//  dec_jump     in   1      J/JAL decoded in decode
//  dec_halt     in   1      HALT decoded in decode
//  ex_dread     in   1      load in EX (ID/EX reg dread)
//  ex_wsel      in   5      dest reg of instr in EX
//  mem_dread    in   1      load in MEM (EX/MEM reg)
//  mem_dwrite   in   1      store in MEM
//  mem_br_taken in   1      BEQ/BNE resolved taken in MEM
//  mem_jr       in   1      JR in MEM
//  wb_halt      in   1      halt reached MEM/WB reg output
//  IF_EN,ID_EN,EX_EN,MEM_EN              out 1 each  stage register load enables
//  IF_FLUSH,ID_FLUSH,EX_FLUSH,MEM_FLUSH  out 1 each  stage bubble insert
//  halt         out  1      drain mode: flushes preserve *_halt bits
//  pc_en        out  1      PC register update
//  pc_sel       out  2      pc_sel_t: PC_SEQ, PC_BR, PC_JMP, PC_JR
//  cpu_halt     out  1      sticky halted indication
//  stall_cnt    out  CNT_W  cycles with pc_en=0 while in RUN
//  flush_cnt    out  CNT_W  squash events (branch/JR/jump)
// BEHAVIOUR
//  Reset (nRST=0, async): state=RUN; counters=0; all EN/FLUSH=0, pc_en=0, pc_sel=PC_SEQ, halt=0, cpu_halt=0.
//  Outputs combinational from state+inputs (zero latency); state/counters registered.
//  dwait = (mem_dread|mem_dwrite) & ~dhit; lduse = ex_dread & ex_wsel!=0 & (ex_wsel==dec_rs | ex_wsel==dec_rt).
//  RUN, priority high->low, one rule applies per cycle:
//   1 dwait: all EN=0, all FLUSH=0, pc_en=0 (full freeze).
//   2 mem_br_taken|mem_jr: IF/ID/EX_FLUSH=1, MEM_EN=1, pc_en=1, pc_sel=PC_BR/PC_JR (JR wins if both); flush_cnt++.
//   3 lduse: pc_en=0, IF_EN=0 (hold), ID_FLUSH=1, EX_EN=MEM_EN=1.
//   4 ~ihit: IF_FLUSH=1, pc_en=0, ID/EX/MEM_EN=1.
//   5 dec_jump: IF_FLUSH=1, pc_en=1, pc_sel=PC_JMP, other EN=1; flush_cnt++.
//   6 dec_halt: as normal advance but pc_en=0, IF_FLUSH=1; next state DRAIN.
//   7 else: all EN=1, pc_en=1, PC_SEQ.
//  DRAIN: halt=1, pc_en=0, IF_FLUSH=1; rules 1-3 still apply; rule 2 (halt was speculative) -> RUN, halt=0 that cycle;
//   wb_halt=1 -> HALTED.
//  HALTED: all EN=0, pc_en=0, cpu_halt=1; exits only via reset.
//  stall_cnt/flush_cnt saturate at all-ones; no increment in HALTED or during dwait for flush_cnt.
//  Simultaneous dec_halt and mem_br_taken: rule 2 wins, stay RUN. lduse under dwait: freeze only.
// STRUCTURE
//  cpu_types_pkg additions: pc_sel_t {PC_SEQ,PC_BR,PC_JMP,PC_JR}, hzstate_t {HZ_RUN,HZ_DRAIN,HZ_HALTED}.
//  One sub-module: hazard_detect (combinational lduse compare); FSM, priority mux, counters in top.
// TESTING
//  T1 reset mid-DRAIN: nRST low 1 cycle -> state RUN, cpu_halt=0, counters=0, all EN=0.
//  T2 lw $3 then add uses $3 (ex_dread=1, ex_wsel=3, dec_rs=3) -> 1 cycle pc_en=0, ID_FLUSH=1, stall_cnt=1.
//  T3 mem_dwrite=1, dhit low 3 cycles -> all EN=0 for 3 cycles; dhit=1 cycle 4 -> normal advance.
//  T4 mem_br_taken=1 with dec_lduse also true -> IF/ID/EX_FLUSH=1, pc_sel=PC_BR, flush_cnt=1.
//  T5 dec_halt, then wb_halt 3 cycles later -> halt=1 for those 3, then cpu_halt=1, EN=0 held.
//  T6 dec_halt then mem_br_taken next cycle -> back to RUN, halt=0, pc_sel=PC_BR; cpu_halt never set.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control slice: PC select codes,
// hazard-controller states and the register-dependency helper.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_JR  = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DRAIN  = 2'd1,
    HZ_HALTED = 2'd2
  } hzstate_t;

  localparam int REG_W = 5;

  // Register $0 is hardwired to zero, so it never creates a true dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] wsel,
                                   input logic [REG_W-1:0] src);
    reg_dep = (wsel != {REG_W{1'b0}}) && (wsel == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds the instruction in decode.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic             ex_dread,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  output logic             lduse
);

  // Pure compare; the loaded value is not forwardable until after MEM.
  assign lduse = ex_dread && (reg_dep(ex_wsel, dec_rs) || reg_dep(ex_wsel, dec_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, PC control, halt drain FSM
// and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_jump,
  input  logic             dec_halt,
  input  logic             ex_dread,
  input  logic [4:0]       ex_wsel,
  input  logic             mem_dread,
  input  logic             mem_dwrite,
  input  logic             mem_br_taken,
  input  logic             mem_jr,
  input  logic             wb_halt,
  output logic             IF_EN,
  output logic             ID_EN,
  output logic             EX_EN,
  output logic             MEM_EN,
  output logic             IF_FLUSH,
  output logic             ID_FLUSH,
  output logic             EX_FLUSH,
  output logic             MEM_FLUSH,
  output logic             halt,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             cpu_halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hzstate_t         state_r;
  hzstate_t         nxt_s;
  logic [CNT_W-1:0] stall_r;
  logic [CNT_W-1:0] flush_r;
  logic             lduse_s;
  logic             dwait_s;
  logic             squash_s;
  logic [3:0]       en_s;
  logic [3:0]       fl_s;
  logic             pc_en_s;
  pc_sel_t          sel_s;
  logic             halt_s;
  logic             cpu_halt_s;
  logic             stall_inc_s;
  logic             flush_inc_s;

  hazard_detect u_hazard_detect (
    .ex_dread (ex_dread),
    .ex_wsel  (ex_wsel),
    .dec_rs   (dec_rs),
    .dec_rt   (dec_rt),
    .lduse    (lduse_s)
  );

  assign dwait_s  = (mem_dread || mem_dwrite) && !dhit;
  assign squash_s = mem_br_taken || mem_jr;

  // Priority mux: stage controls and next state; en/fl are {IF,ID,EX,MEM}.
  always_comb begin
    en_s        = 4'b0000;
    fl_s        = 4'b0000;
    pc_en_s     = 1'b0;
    sel_s       = PC_SEQ;
    halt_s      = 1'b0;
    cpu_halt_s  = 1'b0;
    flush_inc_s = 1'b0;
    nxt_s       = state_r;
    case (state_r)
      HZ_RUN, HZ_DRAIN: begin
        if (dwait_s) begin
          halt_s = (state_r == HZ_DRAIN);
        end else if (squash_s) begin
          // A squash in DRAIN means the halt itself was on the wrong path.
          en_s        = 4'b0001;
          fl_s        = 4'b1110;
          pc_en_s     = 1'b1;
          sel_s       = mem_jr ? PC_JR : PC_BR;
          flush_inc_s = 1'b1;
          nxt_s       = HZ_RUN;
        end else if (lduse_s) begin
          en_s   = 4'b0011;
          fl_s   = 4'b0100;
          halt_s = (state_r == HZ_DRAIN);
        end else if (state_r == HZ_DRAIN) begin
          en_s   = 4'b0111;
          fl_s   = 4'b1000;
          halt_s = 1'b1;
          nxt_s  = wb_halt ? HZ_HALTED : HZ_DRAIN;
        end else if (!ihit) begin
          en_s = 4'b0111;
          fl_s = 4'b1000;
        end else if (dec_jump) begin
          en_s        = 4'b0111;
          fl_s        = 4'b1000;
          pc_en_s     = 1'b1;
          sel_s       = PC_JMP;
          flush_inc_s = 1'b1;
        end else if (dec_halt) begin
          en_s  = 4'b0111;
          fl_s  = 4'b1000;
          nxt_s = HZ_DRAIN;
        end else begin
          en_s    = 4'b1111;
          pc_en_s = 1'b1;
        end
      end
      HZ_HALTED: begin
        cpu_halt_s = 1'b1;
      end
      default: begin
        nxt_s = HZ_RUN;
      end
    endcase
  end

  assign stall_inc_s = (state_r == HZ_RUN) && !pc_en_s;

  // Outputs are held quiet while reset is asserted.
  assign IF_EN     = nRST && en_s[3];
  assign ID_EN     = nRST && en_s[2];
  assign EX_EN     = nRST && en_s[1];
  assign MEM_EN    = nRST && en_s[0];
  assign IF_FLUSH  = nRST && fl_s[3];
  assign ID_FLUSH  = nRST && fl_s[2];
  assign EX_FLUSH  = nRST && fl_s[1];
  assign MEM_FLUSH = nRST && fl_s[0];
  assign halt      = nRST && halt_s;
  assign pc_en     = nRST && pc_en_s;
  assign pc_sel    = nRST ? sel_s : PC_SEQ;
  assign cpu_halt  = nRST && cpu_halt_s;
  assign stall_cnt = stall_r;
  assign flush_cnt = flush_r;

  // State register and saturating performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= HZ_RUN;
      stall_r <= {CNT_W{1'b0}};
      flush_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= nxt_s;
      if (stall_inc_s && (stall_r != CNT_MAX)) begin
        stall_r <= stall_r + CNT_ONE;
      end else begin
        stall_r <= stall_r;
      end
      if (flush_inc_s && (flush_r != CNT_MAX)) begin
        flush_r <= flush_r + CNT_ONE;
      end else begin
        flush_r <= flush_r;
      end
    end
  end

endmodule
